fifo_uart_tx: RTL and testbench

- Drains bytes from a SYNCFIFO-style synchronous FIFO and serialises each byte as a UART 8N1 frame (8 data bits, no parity, 1 or 2 stop bits) on txd.
- Sits on the host-return path: control logic writes response bytes into the FIFO, and this block empties the FIFO toward the USB-UART bridge.
- FIFO read contract: assert fifo_re for one cycle while fifo_emp is low; fifo_rd is valid on the following cycle.

---
 rtl/fifo_uart_tx_pkg.sv | 31 +++
 rtl/fifo_uart_tx_timer.sv | 49 ++++
 rtl/fifo_uart_tx.sv | 179 +++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx_pkg
// Shared types and constants for the FIFO-draining UART 8N1 transmitter.
//   state_e       : transmitter FSM states (3-bit encoding)
//   DATA_BITS     : data bits per UART frame
//   TXD_IDLE      : line level while no frame is on the wire
//   LAST_DATA_BIT : bit index of the final data bit
//   reload_value  : divider reload so that a bit lasts exactly div clocks
// -----------------------------------------------------------------------------
package fifo_uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP   = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_e;

  localparam int         DATA_BITS     = 8;
  localparam logic       TXD_IDLE      = 1'b1;
  localparam logic [2:0] LAST_DATA_BIT = 3'(DATA_BITS - 1);

  // The divider counts reload..0 inclusive, so a reload of div-1 gives a
  // period of exactly div clocks.
  function automatic logic [15:0] reload_value(input logic [15:0] div);
    return div - 16'd1;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_timer.sv
// -----------------------------------------------------------------------------
// uart_bit_timer
// Down-counting bit-period divider. Produces one tick every div clocks and is
// re-phased by restart. Written to be shared with a future UART receiver.
//   clk       : system clock
//   rst       : synchronous active-high reset (counter to 0)
//   restart   : reload the counter; the next tick lands div clocks later
//   div[15:0] : clocks per bit, legal range 2..65535
//   tick      : high on the last clock of a bit period
//   tick_next : high when tick will be high on the next clock
// -----------------------------------------------------------------------------
module uart_bit_timer
  import fifo_uart_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        restart,
  input  logic [15:0] div,
  output logic        tick,
  output logic        tick_next
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  assign tick = (cnt_q == 16'd0);

  // With div >= 2 a reload never lands on 0, so the only way to tick next
  // clock is to be at 1 now without being restarted.
  assign tick_next = !restart && (cnt_q == 16'd1);

  always_comb begin
    cnt_d = cnt_q - 16'd1;
    // Reloading on tick itself (not one clock later) keeps consecutive bits
    // exactly div clocks long, so a frame never drifts.
    if (restart || tick) begin
      cnt_d = reload_value(div);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
// Drains bytes from a synchronous FIFO and sends each as a UART 8N1 frame
// (start bit, 8 data bits LSB first, STOP_BITS stop bits) on txd.
//
// Parameters:
//   BAUD_DIV  : clocks per UART bit, legal range 2..65535
//   STOP_BITS : 1 or 2
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous reset, active-high
//   fifo_rd   in   FIFO read data, valid the cycle after fifo_re
//   fifo_emp  in   FIFO empty flag (registered inside the FIFO)
//   fifo_re   out  FIFO read enable, one-cycle pulse
//   tx_en     in   permits starting a new frame
//   txd       out  UART serial out, idle high
//   busy      out  high in every state except IDLE
//   done      out  one-cycle pulse on the last clock of the stop period
//   sent_cnt  out  completed frame count, wraps modulo 2^16
//
// FIFO read handshake: fifo_re is a one-cycle request issued only when
// fifo_emp was low (and tx_en high) in IDLE; the FIFO answers with fifo_rd one
// cycle later, which is captured in LOAD. There is no back-pressure: each pop
// is consumed exactly once. fifo_emp is not re-sampled until the frame ends,
// long after the FIFO has updated it.
//
// All outputs are flops loaded from the next-state decode, so each output is a
// pure function of the current state (Moore) with no combinational path from
// inputs.
// -----------------------------------------------------------------------------
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int BAUD_DIV  = 434,
  parameter int STOP_BITS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  fifo_rd,
  input  logic        fifo_emp,
  output logic        fifo_re,
  input  logic        tx_en,
  output logic        txd,
  output logic        busy,
  output logic        done,
  output logic [15:0] sent_cnt
);

  localparam logic [15:0] DIV           = 16'(BAUD_DIV);
  localparam logic [2:0]  LAST_STOP_BIT = 3'(STOP_BITS - 1);

  state_e      state_q,    state_d;
  logic [7:0]  shift_q,    shift_d;
  logic [2:0]  bit_q,      bit_d;
  logic        txd_q,      txd_d;
  logic        fifo_re_q,  fifo_re_d;
  logic        busy_q,     busy_d;
  logic        done_q,     done_d;
  logic [15:0] sent_cnt_q, sent_cnt_d;

  logic timer_restart;
  logic tick;
  logic tick_next;

  uart_bit_timer u_timer (
    .clk       (clk),
    .rst       (rst),
    .restart   (timer_restart),
    .div       (DIV),
    .tick      (tick),
    .tick_next (tick_next)
  );

  // Next-state and datapath decode.
  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    bit_d         = bit_q;
    timer_restart = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (tx_en && !fifo_emp) begin
          state_d = POP;
        end
      end
      POP: begin
        state_d = LOAD;
      end
      LOAD: begin
        shift_d       = fifo_rd;
        bit_d         = 3'd0;
        // Phase the divider so START lasts exactly BAUD_DIV clocks.
        timer_restart = 1'b1;
        state_d       = START;
      end
      START: begin
        if (tick) begin
          bit_d   = 3'd0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == LAST_DATA_BIT) begin
            bit_d   = 3'd0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      STOP: begin
        // bit_q counts stop bits here.
        if (tick) begin
          if (bit_q == LAST_STOP_BIT) begin
            bit_d   = 3'd0;
            state_d = IDLE;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from the next state, so the registered outputs line up with
  // the state they describe.
  always_comb begin
    txd_d = TXD_IDLE;
    unique case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      default: txd_d = TXD_IDLE;
    endcase

    fifo_re_d = (state_d == POP);
    busy_d    = (state_d != IDLE);

    // done must sit on the final stop clock, so it is raised one clock early:
    // staying in STOP on the last stop bit with the divider about to tick.
    done_d     = (state_d == STOP) && (bit_d == LAST_STOP_BIT) && tick_next;
    sent_cnt_d = sent_cnt_q + 16'(done_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= 8'h00;
      bit_q      <= 3'd0;
      txd_q      <= TXD_IDLE;
      fifo_re_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sent_cnt_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_q      <= bit_d;
      txd_q      <= txd_d;
      fifo_re_q  <= fifo_re_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sent_cnt_q <= sent_cnt_d;
    end
  end

  assign txd      = txd_q;
  assign fifo_re  = fifo_re_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign sent_cnt = sent_cnt_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo_uart_tx
// Bench for fifo_uart_tx with BAUD_DIV=3, STOP_BITS=2. A behavioural FIFO
// feeds the DUT; every popped byte becomes an expected frame, and a line
// monitor captures each frame from its start edge and compares it with the
// waveform built directly from the byte (start, 8 data bits LSB first, stop).
// -----------------------------------------------------------------------------
module tb_fifo_uart_tx;

  localparam int BAUD_DIV   = 3;
  localparam int STOP_BITS  = 2;
  localparam int FRAME_CLKS = (1 + 8 + STOP_BITS) * BAUD_DIV;
  localparam int MEM_N      = 256;
  localparam int DRAIN_MAX  = 4000;

  // ---------------------------------------------------------------- clock/reset
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_en = 1'b0;
  logic [7:0]  fifo_rd;
  logic        fifo_emp;
  logic        fifo_re;
  logic        txd;
  logic        busy;
  logic        done;
  logic [15:0] sent_cnt;

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .BAUD_DIV  (BAUD_DIV),
    .STOP_BITS (STOP_BITS)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .fifo_rd  (fifo_rd),
    .fifo_emp (fifo_emp),
    .fifo_re  (fifo_re),
    .tx_en    (tx_en),
    .txd      (txd),
    .busy     (busy),
    .done     (done),
    .sent_cnt (sent_cnt)
  );

  // ---------------------------------------------------------------- bookkeeping
  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  mem [MEM_N];
  int          wr_ptr  = 0;
  int          rd_ptr  = 0;
  int          pop_cnt = 0;
  logic [7:0]  exp_q [$];
  logic [15:0] exp_cnt = 16'h0000;
  logic [15:0] cnt_off = 16'h0000;
  logic        in_frame = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- driver tasks
  task automatic push(input logic [7:0] b);
    mem[wr_ptr % MEM_N] = b;
    wr_ptr++;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!(wr_ptr == rd_ptr && exp_q.size() == 0 && !in_frame && !busy) && n < DRAIN_MAX);
    check({"drain_timeout_", tag}, 32'(n >= DRAIN_MAX), 32'd0);
  endtask

  task automatic wait_pop(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!fifo_re && n < 200);
    check({"pop_timeout_", tag}, 32'(fifo_re), 32'd1);
  endtask

  // ---------------------------------------------------------------- FIFO model + scoreboard monitor
  initial begin : model_mon
    logic [7:0] b;
    logic       prev_re;
    logic       b2b;
    logic       emp_last;
    logic       ten_last;
    logic       e;
    int         gap;
    int         nsamp;
    int         bad;
    int         pos;
    logic       s_txd  [FRAME_CLKS];
    logic       s_busy [FRAME_CLKS];
    logic       s_done [FRAME_CLKS];

    prev_re  = 1'b0;
    b2b      = 1'b0;
    emp_last = 1'b1;
    ten_last = 1'b0;
    gap      = 0;
    nsamp    = 0;
    fifo_emp = 1'b1;
    fifo_rd  = 8'h00;

    forever begin
      @(posedge clk);
      // fifo_re seen here belongs to the POP cycle just ending; the IDLE
      // decision behind it was taken one edge earlier.
      if (fifo_re && !rst) begin
        check("pop_while_empty", 32'(emp_last), 32'd0);
        check("pop_without_tx_en", 32'(ten_last), 32'd1);
        if (rd_ptr != wr_ptr) begin
          b = mem[rd_ptr % MEM_N];
          rd_ptr++;
          pop_cnt++;
          fifo_rd <= b;
          exp_q.push_back(b);
        end
      end
      emp_last = fifo_emp;
      ten_last = tx_en;
      fifo_emp <= (rd_ptr == wr_ptr);

      @(negedge clk);
      if (rst) begin
        in_frame = 1'b0;
        nsamp    = 0;
        exp_q.delete();
        exp_cnt  = 16'h0000;
        b2b      = 1'b0;
        gap      = 0;
        prev_re  = 1'b0;
      end else begin
        if (fifo_re) begin
          check("fifo_re_width", 32'(prev_re), 32'd0);
        end
        prev_re = fifo_re;

        if (!in_frame) begin
          if (done) begin
            check("done_outside_frame", 32'(done), 32'd0);
          end
          if (txd == 1'b0) begin
            if (b2b) begin
              check("b2b_gap", 32'(gap), 32'd3);
            end
            b2b      = 1'b0;
            in_frame = 1'b1;
            nsamp    = 0;
          end else begin
            gap++;
          end
        end

        if (in_frame) begin
          s_txd[nsamp]  = txd;
          s_busy[nsamp] = busy;
          s_done[nsamp] = done;
          nsamp++;
          if (nsamp == FRAME_CLKS) begin
            in_frame = 1'b0;
            gap      = 0;
            b2b      = tx_en && !fifo_emp;
            if (exp_q.size() == 0) begin
              check("unexpected_frame", 32'(exp_q.size()), 32'd1);
            end else begin
              b   = exp_q.pop_front();
              bad = 0;
              for (int k = 0; k < FRAME_CLKS; k++) begin
                pos = k / BAUD_DIV;
                if (pos == 0)      e = 1'b0;
                else if (pos <= 8) e = b[pos-1];
                else               e = 1'b1;
                if (s_txd[k] !== e || s_busy[k] !== 1'b1 || s_done[k] !== (k == FRAME_CLKS - 1))
                  bad++;
              end
              check($sformatf("frame_%02h_bad_clocks", b), 32'(bad), 32'd0);
              exp_cnt = exp_cnt + 16'd1;
              check("sent_cnt_at_done", 32'(sent_cnt), 32'(16'(exp_cnt + cnt_off)));
            end
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  initial begin : stim
    int p0;
    int bad_re;
    int bad_busy;
    int bad_txd;

    rst   = 1'b1;
    tx_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_txd",      32'(txd),      32'd1);
    check("rst_fifo_re",  32'(fifo_re),  32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_done",     32'(done),     32'd0);
    check("rst_sent_cnt", 32'(sent_cnt), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Empty FIFO with tx_en high: nothing may move.
    tx_en    = 1'b1;
    bad_re   = 0;
    bad_busy = 0;
    bad_txd  = 0;
    repeat (100) begin
      @(negedge clk);
      bad_re   += int'(fifo_re);
      bad_busy += int'(busy);
      bad_txd  += int'(!txd);
    end
    check("empty_fifo_re", 32'(bad_re),   32'd0);
    check("empty_busy",    32'(bad_busy), 32'd0);
    check("empty_txd_low", 32'(bad_txd),  32'd0);

    // Non-empty FIFO with tx_en low: no pop.
    #1 tx_en = 1'b0;
    p0 = pop_cnt;
    push(8'hA5);
    repeat (50) @(negedge clk);
    check("tx_en_low_pops", 32'(pop_cnt - p0), 32'd0);
    check("tx_en_low_busy", 32'(busy),         32'd0);

    // Single byte.
    #1 tx_en = 1'b1;
    wait_idle("a5");
    check("a5_pops",     32'(pop_cnt - p0), 32'd1);
    check("a5_sent_cnt", 32'(sent_cnt),     32'd1);

    // Back-to-back pair.
    tx_en = 1'b0;
    p0 = pop_cnt;
    push(8'h00);
    push(8'hFF);
    @(negedge clk);
    #1 tx_en = 1'b1;
    wait_idle("b2b");
    check("b2b_pops",     32'(pop_cnt - p0), 32'd2);
    check("b2b_sent_cnt", 32'(sent_cnt),     32'd3);

    // Two stop bits on 8'h81.
    p0 = pop_cnt;
    push(8'h81);
    wait_idle("81");
    check("x81_pops",     32'(pop_cnt - p0), 32'd1);
    check("x81_sent_cnt", 32'(sent_cnt),     32'd4);

    // Drop tx_en in DATA: the frame finishes, the next byte stays queued.
    p0 = pop_cnt;
    push(8'h3C);
    push(8'h5A);
    wait_pop("drop");
    repeat (8) @(posedge clk);
    #1 tx_en = 1'b0;
    repeat (100) @(negedge clk);
    check("drop_pops",     32'(pop_cnt - p0),   32'd1);
    check("drop_busy",     32'(busy),           32'd0);
    check("drop_sent_cnt", 32'(sent_cnt),       32'd5);
    check("drop_left",     32'(wr_ptr - rd_ptr), 32'd1);
    #1 tx_en = 1'b1;
    wait_idle("drop_resume");
    check("drop_resume_sent_cnt", 32'(sent_cnt), 32'd6);

    // Reset during DATA bit 3 of the first of three bytes.
    p0 = pop_cnt;
    push(8'h12);
    push(8'h34);
    push(8'h56);
    wait_pop("reset");
    repeat (14) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_txd",      32'(txd),      32'd1);
    check("midrst_busy",     32'(busy),     32'd0);
    check("midrst_sent_cnt", 32'(sent_cnt), 32'd0);
    check("midrst_fifo_re",  32'(fifo_re),  32'd0);
    check("midrst_done",     32'(done),     32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_idle("after_reset");
    check("after_reset_sent_cnt", 32'(sent_cnt),     32'd2);
    check("after_reset_pops",     32'(pop_cnt - p0), 32'd3);

    // Random bytes arriving in random bursts.
    p0 = pop_cnt;
    for (int i = 0; i < 24; i++) begin
      push(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 60)) @(negedge clk);
        #1;
      end
    end
    wait_idle("random");
    check("random_pops",     32'(pop_cnt - p0), 32'd24);
    check("random_sent_cnt", 32'(sent_cnt),     32'd26);

    // Counter wrap: preload 16'hFFFF, one more frame brings it to 0.
    cnt_off = 16'hFFFF - exp_cnt;
    force u_dut.sent_cnt_q = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    release u_dut.sent_cnt_q;
    check("wrap_preload", 32'(sent_cnt), 32'h0000FFFF);
    #1 push(8'h6E);
    wait_idle("wrap");
    check("wrap_sent_cnt", 32'(sent_cnt), 32'h00000000);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // ---------------------------------------------------------------- watchdog
  initial begin : watchdog
    #500000;
    n_err++;
    $display("FAIL watchdog: simulation did not complete within 50000 clocks");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
